dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
- Memory-stage access controller that sits directly upstream of the word-only data memory.
- Turns pipeline load/store requests (byte, halfword, word) into word accesses on the data memory.
- Sub-word stores use a two-cycle read-modify-write with a one-cycle pipeline stall.
- Load data is extracted, sign- or zero-extended, and registered for write-back; misaligned or reserved-size accesses are flagged.

Parameters:
- ADDR_W, 32, width of request and memory address buses.
- ERR_RESERVED_SIZE, 1, when 1 the size code 2'b11 raises addr_err; when 0 it is treated as word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  memory request present this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  zero-extend load (lbu/lhu).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- stall  output  1  hold the request and the upstream pipeline.
- rdata  output  32  registered, extended load result.
- rvalid  output  1  rdata valid (one-cycle pulse).
- addr_err  output  1  misaligned/reserved access (one-cycle pulse).
- dm_we  output  1  memory write enable.
- dm_addr  output  ADDR_W  word-aligned memory address (bits [1:0] = 0).
- dm_din  output  32  memory write data.
- dm_dout  input  32  asynchronous memory read data for dm_addr.

Behaviour:
- Little-endian lanes: byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- FSM states are IDLE and RMW_WR. Reset puts the FSM in IDLE and clears rdata, rvalid, addr_err and the internal latches to 0.
- dm_we is forced to 0 while reset is high.
- IDLE with req_valid and misaligned/reserved access:
  - No dm_we.
  - addr_err=1 in the next cycle.
  - stall=0.
- IDLE, word store: dm_we=1, dm_addr=req_addr&~3, dm_din=req_wdata in the same cycle; stall=0.
- IDLE, sub-word store:
  - stall=1 combinationally.
  - dm_we=0.
  - dm_addr=req_addr&~3.
  - At the edge, capture dm_dout, the addr, req_wdata low lane data and the size; go to RMW_WR.
- RMW_WR:
  - dm_we=1, dm_addr=latched word address.
  - dm_din = captured word with the target lane replaced by the latched data.
  - stall=0; req inputs are ignored; next state is IDLE.
  - Upstream keeps the request stable while stall=1, then advances after the RMW_WR cycle; the same store is not re-accepted.
- IDLE, load:
  - dm_addr=req_addr&~3.
  - At the edge, rdata <= selected lane, sign-extended (or zero-extended if req_unsigned; word loads pass through).
  - rvalid=1 in the next cycle; rdata holds its value until the next load.
- rvalid and addr_err are single-cycle pulses.
- Idle cycles drive dm_addr=req_addr&~3 and dm_din=req_wdata.
- Reset asserted in RMW_WR: write is suppressed, FSM returns to IDLE, stall=0.
- Back-to-back: a request in the cycle after RMW_WR sees the freshly written word (the memory write lands at the end of RMW_WR).
- Load/store latency is 1 cycle for everything except sub-word stores (2 cycles, 1 stall).

Optional Feature:
- Macro DM_ACCESS_TRACE_EN.
- Defined: on every clock edge where dm_we=1 and reset=0, print "*%h <= %h" with the word-aligned dm_addr and dm_din, and print "!addr_err %h" on each error.
- Not defined: no simulation output; logic is identical.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF -> same cycle dm_we=1, dm_addr=0x10, dm_din=0xDEADBEEF, stall=0.
- mem[0x10]=0x11223344; sb addr 0x12 data 0x000000AB:
  - -> cycle T: stall=1, dm_we=0.
  - -> cycle T+1: dm_we=1, dm_addr=0x10, dm_din=0x11AB3344.
- mem[0x20]=0x80FF0000:
  - lb 0x23 -> T+1 rvalid=1, rdata=0xFFFFFF80.
  - lbu 0x23 -> rdata=0x00000080.
  - lh 0x22 -> rdata=0xFFFF80FF.
- sh addr 0x11 or lw addr 0x22 -> T+1 addr_err=1, rvalid=0, dm_we stays 0 throughout.
- sb 0x12 with reset raised during RMW_WR cycle -> dm_we=0, next cycle stall=0, rvalid=0, mem[0x10] unchanged.
- sh 0x20 data 0x0000BEEF onto 0x80FF0000, then lw 0x20 immediately -> write dm_din=0x80FFBEEF; lw rdata=0x80FFBEEF at next cycle.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// Memory-stage access controller in front of a word-only data memory.
// Turns byte/halfword/word loads and stores into word accesses. Sub-word
// stores use a read-modify-write that stalls the pipeline for one cycle.
// Loads are lane-selected, sign/zero-extended and registered for write-back.
// Misaligned and reserved-size requests raise a one-cycle addr_err pulse.
//
// Optional build macro: DM_ACCESS_TRACE_EN
//    When defined, every memory write and every address error is printed
//    during simulation. The hardware logic is the same either way.

module dm_access_ctrl #(
   parameter int ADDR_W            = 32,
   parameter bit ERR_RESERVED_SIZE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              addr_err,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   input  logic [31:0]       dm_dout
);

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   state_t state, state_next;

   logic [ADDR_W-1:0] word_addr;
   logic              size_err;
   logic              is_word;
   logic              accept_err;
   logic              load_fire;
   logic              rmw_capture;

   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [31:0]       load_ext;

   logic [ADDR_W-1:0] lat_addr;
   logic [1:0]        lat_lane;
   logic [15:0]       lat_data;
   logic              lat_half;
   logic [31:0]       lat_word;
   logic [31:0]       merged_word;

   assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

   // Classify the request size: alignment check and whether it is a full-word access
   always_comb begin
      size_err = 1'b0;
      is_word  = 1'b0;
      case (req_size)
         SIZE_BYTE: size_err = 1'b0;
         SIZE_HALF: size_err = req_addr[0];
         SIZE_WORD: begin
            size_err = (req_addr[1:0] != 2'b00);
            is_word  = 1'b1;
         end
         SIZE_RSVD: begin
            if (ERR_RESERVED_SIZE) begin
               size_err = 1'b1;
            end else begin
               size_err = (req_addr[1:0] != 2'b00);
               is_word  = 1'b1;
            end
         end
         default: size_err = 1'b1;
      endcase
   end

   // Pick the addressed byte and halfword lane out of the memory read word
   always_comb begin
      load_byte = dm_dout[7:0];
      case (req_addr[1:0])
         2'd0: load_byte = dm_dout[7:0];
         2'd1: load_byte = dm_dout[15:8];
         2'd2: load_byte = dm_dout[23:16];
         2'd3: load_byte = dm_dout[31:24];
         default: load_byte = dm_dout[7:0];
      endcase
      load_half = req_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
   end

   // Extend the selected lane to 32 bits; word-sized loads pass straight through
   always_comb begin
      load_ext = dm_dout;
      if (req_size == SIZE_BYTE) begin
         load_ext = {{24{load_byte[7] & ~req_unsigned}}, load_byte};
      end else if (req_size == SIZE_HALF) begin
         load_ext = {{16{load_half[15] & ~req_unsigned}}, load_half};
      end
   end

   // Rebuild the stored word with the latched store data dropped into its lane
   always_comb begin
      merged_word = lat_word;
      if (lat_half) begin
         if (lat_lane[1]) begin
            merged_word = {lat_data, lat_word[15:0]};
         end else begin
            merged_word = {lat_word[31:16], lat_data};
         end
      end else begin
         case (lat_lane)
            2'd0: merged_word = {lat_word[31:8], lat_data[7:0]};
            2'd1: merged_word = {lat_word[31:16], lat_data[7:0], lat_word[7:0]};
            2'd2: merged_word = {lat_word[31:24], lat_data[7:0], lat_word[15:0]};
            2'd3: merged_word = {lat_data[7:0], lat_word[23:0]};
            default: merged_word = lat_word;
         endcase
      end
   end

   // Next-state and memory-side outputs; reset always suppresses the write strobe
   always_comb begin
      state_next  = state;
      stall       = 1'b0;
      dm_we       = 1'b0;
      dm_addr     = word_addr;
      dm_din      = req_wdata;
      accept_err  = 1'b0;
      load_fire   = 1'b0;
      rmw_capture = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (size_err) begin
                  accept_err = 1'b1;
               end else if (req_we) begin
                  if (is_word) begin
                     dm_we = 1'b1;
                  end else begin
                     stall       = 1'b1;
                     rmw_capture = 1'b1;
                     state_next  = RMW_WR;
                  end
               end else begin
                  load_fire = 1'b1;
               end
            end
         end
         RMW_WR: begin
            dm_we      = 1'b1;
            dm_addr    = lat_addr;
            dm_din     = merged_word;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (reset) begin
         dm_we = 1'b0;
      end
   end

   // State register, registered load result, status pulses and read-modify-write latches
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rdata    <= 32'h0;
         rvalid   <= 1'b0;
         addr_err <= 1'b0;
         lat_addr <= '0;
         lat_lane <= 2'b00;
         lat_data <= 16'h0;
         lat_half <= 1'b0;
         lat_word <= 32'h0;
      end else begin
         state    <= state_next;
         rvalid   <= load_fire;
         addr_err <= accept_err;
         if (load_fire) begin
            rdata <= load_ext;
         end
         if (rmw_capture) begin
            lat_addr <= word_addr;
            lat_lane <= req_addr[1:0];
            lat_data <= req_wdata[15:0];
            lat_half <= (req_size == SIZE_HALF);
            lat_word <= dm_dout;
         end
      end
   end

`ifdef DM_ACCESS_TRACE_EN
   // Simulation trace of memory writes and rejected requests
   always @(posedge clk) begin
      if (dm_we && !reset) begin
         $display("*%h <= %h", dm_addr, dm_din);
      end
      if (accept_err && !reset) begin
         $display("!addr_err %h", req_addr);
      end
   end
`else
`endif

endmodule
